player_hit_detector: RTL
========================

# player_hit_detector

Upstream stage of the on-screen health counter: detects pixel-level overlap between the player sprite and any enemy sprite during the visible scan and condenses it into exactly one clean `player_collision` pulse per hit. Each hit is followed by a frame-counted invulnerability window, and the block stops generating hits after a fixed number of them. It sits between the sprite renderers / VGA controller and the health display, and also drives player blink and game-over signals to the game-state logic.

## Interface
Parameters:
- `PULSE_LEN`, 4: `player_collision` high time in `Clk` cycles (1..15).
- `INVULN_FRAMES`, 60: frames of invulnerability after each hit (1..255).
- `MAX_HITS`, 5: hit count that ends the game (1..15).

Ports:
- `Clk`  in  1  system clock; all logic on its rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `vsync`  in  1  VGA vertical sync (active-high pulse); asynchronous to `Clk`, synchronized internally.
- `blank_n`  in  1  high while the scan is in the visible area.
- `player_on`  in  1  current pixel belongs to the player sprite.
- `enemy_on`  in  1  current pixel belongs to any enemy sprite.
- `enable`  in  1  gameplay active; hits register only while high.
- `player_collision`  out  1  hit pulse to the health counter.
- `invuln`  out  1  player currently invulnerable.
- `blink`  out  1  player-sprite hide strobe.
- `hit_count`  out  4  hits taken since reset, saturates at `MAX_HITS`.
- `game_over`  out  1  `MAX_HITS` reached.

## Operation
- Frame tick: `vsync` passes through a 2-flop synchronizer, then a rising-edge detect, producing a 1-cycle `frame_tick`.
- Overlap latch: `ovl` is set on any cycle with `blank_n & player_on & enemy_on`. On `frame_tick` the evaluated value is `ovl | (blank_n & player_on & enemy_on)`, and `ovl` clears in the same cycle.
- FSM states:
  - ARMED:
    - On `frame_tick` with evaluated overlap = 1 and `enable` = 1: `hit_count` += 1, pulse counter loads `PULSE_LEN`, go to PULSE.
    - Otherwise stay in ARMED.
  - PULSE:
    - `player_collision` = 1; pulse counter decrements each cycle.
    - When the counter reaches 0: if `hit_count == MAX_HITS`, go to DEAD; else load the frame counter with `INVULN_FRAMES` and go to COOLDOWN.
  - COOLDOWN:
    - Overlap is ignored, though `ovl` still clears on every tick.
    - Each `frame_tick` decrements the frame counter; the tick that takes it 1→0 moves to ARMED.
    - `enable` has no effect in this state.
  - DEAD: terminal; `game_over` = 1; only `reset_n` exits.
- `invuln` = 1 in PULSE, COOLDOWN and DEAD.
- `hit_count` never exceeds `MAX_HITS`. The frame counter is 8 bits wide.
- A `frame_tick` arriving during PULSE is not evaluated as a hit. `ovl` still clears on that tick.

## Timing
- Reset values (async, while `reset_n` = 0):
  - state = ARMED; `ovl`, counters and synchronizer flops = 0.
  - Outputs: `player_collision` = 0, `invuln` = 0, `blink` = 0, `hit_count` = 0, `game_over` = 0.
- `frame_tick` latency: 3 `Clk` edges after `vsync` rises (2 synchronizer flops + edge register).
- `player_collision` rises on the edge after the qualifying `frame_tick` and stays high exactly `PULSE_LEN` cycles. `hit_count` updates on that same edge.
- `invuln` rises together with `player_collision` and falls on the edge after the final COOLDOWN tick.
- Reset asserted mid-PULSE forces `player_collision` low immediately (asynchronously). No partial pulse resumes after release.
- All outputs are registered.

## Configuration
- `PLAYER_HIT_BLINK_EN` defined:
  - `blink` = `invuln & frame_cnt[2]` in COOLDOWN, toggling every 4 frames.
  - `blink` = 1 in PULSE.
  - `blink` = 0 in ARMED and DEAD.
- Not defined: `blink` is tied to 0 and the blink logic is absent.
- No other behaviour differs between the two builds.

## Test plan
- Overlap on 10 pixels in frame 1, `enable` = 1 → after the next `vsync` rise + 4 cycles, `player_collision` high for 4 cycles, `hit_count` = 1, `invuln` = 1.
- Continuous overlap for 70 frames, `INVULN_FRAMES` = 60 → exactly 2 pulses. The second pulse follows the 61st tick after the first.
- 5 spaced hits with `MAX_HITS` = 5 → `hit_count` = 5, `game_over` = 1. Further overlap yields no pulse; `hit_count` stays 5.
- Overlap asserted only on the cycle coinciding with `frame_tick` → counted for the closing frame, one pulse. Overlap with `blank_n` = 0 → no pulse.
- `reset_n` low during cycle 2 of PULSE → all outputs 0 immediately. After release, no overlap → no pulse.
- With `PLAYER_HIT_BLINK_EN` defined → `blink` toggles every 4 frames during COOLDOWN. Without the macro → `blink` = 0 throughout.

Source files
------------

// File: rtl/player_hit_detector.sv
// Sprite-overlap hit detector: one collision pulse per hit, frame-counted invulnerability, game over after MAX_HITS.
// Optional blink strobe during invulnerability is built when PLAYER_HIT_BLINK_EN is defined.
`timescale 1ns/1ps

module player_hit_detector #(
    parameter int PULSE_LEN     = 4,
    parameter int INVULN_FRAMES = 60,
    parameter int MAX_HITS      = 5
) (
    input  logic       Clk,
    input  logic       reset_n,
    input  logic       vsync,
    input  logic       blank_n,
    input  logic       player_on,
    input  logic       enemy_on,
    input  logic       enable,
    output logic       player_collision,
    output logic       invuln,
    output logic       blink,
    output logic [3:0] hit_count,
    output logic       game_over
);

    localparam logic [1:0] ST_ARMED    = 2'd0;
    localparam logic [1:0] ST_PULSE    = 2'd1;
    localparam logic [1:0] ST_COOLDOWN = 2'd2;
    localparam logic [1:0] ST_DEAD     = 2'd3;

    localparam logic [3:0] PULSE_INIT = 4'(PULSE_LEN);
    localparam logic [7:0] FRAME_INIT = 8'(INVULN_FRAMES);
    localparam logic [3:0] MAX_COUNT  = 4'(MAX_HITS);

    logic       vsync_meta;
    logic       vsync_sync;
    logic       vsync_prev;
    logic       frame_tick;
    logic       ovl;
    logic       pixel_hit;
    logic       overlap_eval;
    logic [1:0] state;
    logic [1:0] state_nxt;
    logic [3:0] pulse_cnt;
    logic [3:0] pulse_cnt_nxt;
    logic [7:0] frame_cnt;
    logic [7:0] frame_cnt_nxt;
    logic [3:0] hit_count_nxt;

    // vsync is asynchronous to Clk: two-flop synchronizer, then a registered rising-edge detect.
    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            vsync_meta <= 1'b0;
            vsync_sync <= 1'b0;
            vsync_prev <= 1'b0;
            frame_tick <= 1'b0;
        end else begin
            vsync_meta <= vsync;
            vsync_sync <= vsync_meta;
            vsync_prev <= vsync_sync;
            frame_tick <= vsync_sync & ~vsync_prev;
        end
    end

    assign pixel_hit    = blank_n & player_on & enemy_on;
    assign overlap_eval = ovl | pixel_hit;

    // The overlap seen on the tick cycle belongs to the frame being closed, so the latch simply clears.
    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            ovl <= 1'b0;
        end else if (frame_tick) begin
            ovl <= 1'b0;
        end else if (pixel_hit) begin
            ovl <= 1'b1;
        end
    end

    always_comb begin
        state_nxt     = state;
        pulse_cnt_nxt = pulse_cnt;
        frame_cnt_nxt = frame_cnt;
        hit_count_nxt = hit_count;
        case (state)
            ST_ARMED: begin
                if (frame_tick && overlap_eval && enable) begin
                    if (hit_count < MAX_COUNT) begin
                        hit_count_nxt = hit_count + 4'd1;
                    end
                    pulse_cnt_nxt = PULSE_INIT;
                    state_nxt     = ST_PULSE;
                end
            end
            ST_PULSE: begin
                pulse_cnt_nxt = pulse_cnt - 4'd1;
                if (pulse_cnt <= 4'd1) begin
                    if (hit_count >= MAX_COUNT) begin
                        state_nxt = ST_DEAD;
                    end else begin
                        frame_cnt_nxt = FRAME_INIT;
                        state_nxt     = ST_COOLDOWN;
                    end
                end
            end
            ST_COOLDOWN: begin
                if (frame_tick) begin
                    frame_cnt_nxt = frame_cnt - 8'd1;
                    if (frame_cnt <= 8'd1) begin
                        state_nxt = ST_ARMED;
                    end
                end
            end
            default: begin
                state_nxt = ST_DEAD;
            end
        endcase
    end

    // Outputs are decoded from the next state so they change on the same edge as the state register.
    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            state            <= ST_ARMED;
            pulse_cnt        <= 4'd0;
            frame_cnt        <= 8'd0;
            hit_count        <= 4'd0;
            player_collision <= 1'b0;
            invuln           <= 1'b0;
            game_over        <= 1'b0;
        end else begin
            state            <= state_nxt;
            pulse_cnt        <= pulse_cnt_nxt;
            frame_cnt        <= frame_cnt_nxt;
            hit_count        <= hit_count_nxt;
            player_collision <= (state_nxt == ST_PULSE);
            invuln           <= (state_nxt != ST_ARMED);
            game_over        <= (state_nxt == ST_DEAD);
        end
    end

`ifdef PLAYER_HIT_BLINK_EN
    // Solid during the pulse, then frame_cnt[2] gives a 4-frame on/off cadence through cooldown.
    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            blink <= 1'b0;
        end else begin
            blink <= (state_nxt == ST_PULSE) |
                     ((state_nxt == ST_COOLDOWN) & frame_cnt_nxt[2]);
        end
    end
`else
    assign blink = 1'b0;
`endif

endmodule
